pipe_addsub: RTL

- Parametrised, pipelined ripple-carry adder/subtractor.
- Successor to the single-bit full-adder cell. Generalised to WIDTH bits, split into STAGES carry-registered segments, with add/subtract mode, signed overflow flag and a valid/ready handshake.
- Sits in datapaths where the full WIDTH-bit carry chain cannot close timing in one cycle.

---
 rtl/pipe_addsub.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/pipe_addsub.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pipe_addsub
// Purpose  : Parametrised pipelined ripple-carry adder/subtractor. The WIDTH
//            bit carry chain is cut into STAGES segments of WIDTH/STAGES bits
//            with a register on the carry between segments. Operand bits that
//            have not been added yet travel alongside the carry. Sum bits that
//            are already done are carried forward, so every bit of one
//            transaction appears at the output in the same cycle.
// Ports    : clk, rst_n         - clock, asynchronous active-low reset
//            in_valid/in_ready  - input handshake (in_ready is combinational)
//            a, b, cin, sub     - operands; sub=1 inverts b (use cin=1 for a-b)
//            out_valid/out_ready- output handshake
//            s, cout, ovf       - result, MSB carry-out, signed overflow
// Params   : WIDTH (>=2), STAGES (1..WIDTH, must divide WIDTH)
// Options  : define PIPE_ADDSUB_SAT_EN to clamp s to signed saturation on
//            overflow. The clamp is in the final stage. cout and ovf still
//            report the unsaturated result.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_addsub #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int c_seg     = WIDTH / STAGES;
    localparam int c_msb     = WIDTH - 1;
    localparam int c_last_lo = WIDTH - c_seg;

    if (WIDTH < 2 || STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("pipe_addsub: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
    end

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;

    assign w_b_eff   = sub ? ~b : b;
    // The whole pipe moves as one unit; it stalls only while the output
    // register holds a result that the consumer has not taken.
    assign w_advance = ~r_out_valid | out_ready;
    assign in_ready  = w_advance;

    // ------------------------------------------------------------------------
    // Intermediate segments 0 .. STAGES-2. Segment k adds bits [c_lo +: c_seg].
    // It registers its carry, the finished low sum bits [c_nx-1:0] and the
    // operand bits still to be added [WIDTH-1:c_nx].
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < STAGES - 1; k++) begin : g_mid
        localparam int c_lo = k * c_seg;
        localparam int c_nx = c_lo + c_seg;

        logic [WIDTH-1:c_lo] w_a_in;
        logic [WIDTH-1:c_lo] w_b_in;
        logic                w_c_in;
        logic                w_v_in;
        logic [c_seg:0]      w_add;
        logic [c_nx-1:0]     w_sum_next;

        logic                r_v;
        logic                r_c;
        logic [c_nx-1:0]     r_sum;
        logic [WIDTH-1:c_nx] r_a;
        logic [WIDTH-1:c_nx] r_b;

        if (k == 0) begin : g_src_port
            assign w_a_in     = a;
            assign w_b_in     = w_b_eff;
            assign w_c_in     = cin;
            assign w_v_in     = in_valid;
            assign w_sum_next = w_add[c_seg-1:0];
        end else begin : g_src_prev
            assign w_a_in     = g_mid[k-1].r_a;
            assign w_b_in     = g_mid[k-1].r_b;
            assign w_c_in     = g_mid[k-1].r_c;
            assign w_v_in     = g_mid[k-1].r_v;
            assign w_sum_next = {w_add[c_seg-1:0], g_mid[k-1].r_sum};
        end

        assign w_add = {1'b0, w_a_in[c_lo +: c_seg]}
                     + {1'b0, w_b_in[c_lo +: c_seg]}
                     + {{c_seg{1'b0}}, w_c_in};

        // Data only loads with a valid transaction. A bubble leaves the old
        // contents in place, so no stage ever picks up undriven inputs.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v   <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= '0;
                r_a   <= '0;
                r_b   <= '0;
            end else if (w_advance) begin
                r_v <= w_v_in;
                if (w_v_in) begin
                    r_c   <= w_add[c_seg];
                    r_sum <= w_sum_next;
                    r_a   <= w_a_in[WIDTH-1:c_nx];
                    r_b   <= w_b_in[WIDTH-1:c_nx];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Final segment: adds the top c_seg bits and writes the output register.
    // ------------------------------------------------------------------------
    logic [WIDTH-1:c_last_lo] w_fa;
    logic [WIDTH-1:c_last_lo] w_fb;
    logic                     w_fc;
    logic                     w_fv;
    logic [c_seg:0]           w_fadd;
    logic [WIDTH-1:0]         w_s_raw;
    logic [WIDTH-1:0]         w_s_fin;
    logic                     w_ovf;

    if (STAGES == 1) begin : g_last_port
        assign w_fa    = a;
        assign w_fb    = w_b_eff;
        assign w_fc    = cin;
        assign w_fv    = in_valid;
        assign w_s_raw = w_fadd[c_seg-1:0];
    end else begin : g_last_chain
        assign w_fa    = g_mid[STAGES-2].r_a;
        assign w_fb    = g_mid[STAGES-2].r_b;
        assign w_fc    = g_mid[STAGES-2].r_c;
        assign w_fv    = g_mid[STAGES-2].r_v;
        assign w_s_raw = {w_fadd[c_seg-1:0], g_mid[STAGES-2].r_sum};
    end

    assign w_fadd = {1'b0, w_fa[c_last_lo +: c_seg]}
                  + {1'b0, w_fb[c_last_lo +: c_seg]}
                  + {{c_seg{1'b0}}, w_fc};

    // Overflow: both addends have the same sign and the result sign differs.
    assign w_ovf = (w_fa[c_msb] == w_fb[c_msb]) && (w_s_raw[c_msb] != w_fa[c_msb]);

`ifdef PIPE_ADDSUB_SAT_EN
    logic [WIDTH-1:0] w_sat_val;
    // When overflow occurs, the sign of a is the direction of the true result.
    assign w_sat_val = w_fa[c_msb] ? {1'b1, {(WIDTH-1){1'b0}}}
                                   : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_s_fin   = w_ovf ? w_sat_val : w_s_raw;
`else
    assign w_s_fin   = w_s_raw;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_s         <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_advance) begin
            r_out_valid <= w_fv;
            if (w_fv) begin
                r_s    <= w_s_fin;
                r_cout <= w_fadd[c_seg];
                r_ovf  <= w_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign s         = r_s;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire
